// File: rtl/rom_download_writer.sv
// Packs loader bytes into 16-bit words, queues them in a small FIFO and issues
// them one at a time to the SDRAM controller over a toggle req/ack handshake.
module rom_download_writer #(
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [23:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic        sdr_we,
  output logic [22:0] sdr_a,
  output logic [1:0]  sdr_ds,
  output logic [15:0] sdr_d,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [23:0] write_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } word_t;

  typedef enum logic [1:0] {SYNC, IDLE, WAIT_ACK} state_t;

  state_t        state;
  logic          dl_q, flush_pend, pend_vld;
  word_t         pend;
  word_t         fifo [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;

  logic          dl_rise, dl_fall, wr_en, same_word, empty, full, pop;
  logic          push_req, push_force, push_ok, drop, pend_vld_nxt;
  logic [22:0]   wr_word;
  logic [1:0]    byte_ds;
  word_t         merged, push_word, pend_nxt, head;

  assign dl_rise   = ioctl_download && !dl_q;
  assign dl_fall   = !ioctl_download && dl_q;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = (state == IDLE) && !empty;
  assign head      = fifo[rd_ptr];
  // Loader writes are held off while the end-of-download flush is outstanding.
  assign wr_en     = ioctl_wr && ioctl_download && !flush_pend;
  assign wr_word   = BASE_ADDR + ioctl_addr[23:1];
  assign byte_ds   = ioctl_addr[0] ? 2'b10 : 2'b01;
  assign same_word = pend_vld && (pend.a == wr_word);

  always_comb begin
    merged    = pend;
    merged.ds = pend.ds | byte_ds;
    if (ioctl_addr[0]) merged.d[15:8] = ioctl_dout;
    else               merged.d[7:0]  = ioctl_dout;
    push_req     = 1'b0;
    push_force   = 1'b0;
    push_word    = pend;
    pend_vld_nxt = pend_vld;
    pend_nxt     = pend;
    if (flush_pend) begin
      push_req   = pend_vld;
      push_force = 1'b1;
      if (!full || pop) pend_vld_nxt = 1'b0;
    end else if (wr_en) begin
      if (same_word) begin
        if (merged.ds == 2'b11) begin
          push_req     = 1'b1;
          push_word    = merged;
          pend_vld_nxt = 1'b0;
        end else begin
          pend_nxt = merged;
        end
      end else begin
        push_req     = pend_vld;
        pend_vld_nxt = 1'b1;
        pend_nxt.a   = wr_word;
        pend_nxt.ds  = byte_ds;
        pend_nxt.d   = ioctl_addr[0] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && !push_ok && !push_force;
  assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop);

  assign sdr_we = 1'b1;
  assign busy   = pend_vld || !empty || (state == WAIT_ACK);

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      dl_q        <= 1'b0;
      flush_pend  <= 1'b0;
      pend_vld    <= 1'b0;
      pend        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      ioctl_wait  <= 1'b0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      write_count <= '0;
      sdr_req     <= sdr_ack;
      sdr_a       <= '0;
      sdr_ds      <= '0;
      sdr_d       <= '0;
    end else begin
      dl_q       <= ioctl_download;
      pend_vld   <= pend_vld_nxt;
      pend       <= pend_nxt;
      flush_pend <= flush_pend ? (pend_vld && !push_ok) : (dl_fall && pend_vld);
      count      <= count_nxt;
      ioctl_wait <= (count_nxt >= (AW+1)'(FIFO_DEPTH-1));
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      if (drop)         overflow <= 1'b1;
      else if (dl_rise) overflow <= 1'b0;

      if (dl_rise)
        done <= 1'b0;
      else if (!ioctl_download && !pend_vld && !flush_pend && empty && state == IDLE)
        done <= 1'b1;

      if (dl_rise)
        write_count <= '0;
      else if (state == WAIT_ACK && sdr_ack == sdr_req)
        write_count <= write_count + 24'd1;

      case (state)
        SYNC: state <= IDLE;
        IDLE: if (!empty) begin
          sdr_a   <= head.a;
          sdr_ds  <= head.ds;
          sdr_d   <= head.d;
          sdr_req <= ~sdr_req;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: if (sdr_ack == sdr_req) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_download_writer.sv
// Bench for rom_download_writer: directed scenarios plus randomized byte streams
// compared against a word-packing reference model.
module tb_rom_download_writer;
  localparam logic [22:0] BASE = 23'h100000;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } w_t;

  logic        clk = 0, reset = 1;
  logic        ioctl_download = 0, ioctl_wr = 0;
  logic [23:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, sdr_req, sdr_ack = 0, sdr_we;
  logic [22:0] sdr_a;
  logic [1:0]  sdr_ds;
  logic [15:0] sdr_d;
  logic        busy, done, overflow;
  logic [23:0] write_count;

  rom_download_writer #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_we(sdr_we), .sdr_a(sdr_a),
    .sdr_ds(sdr_ds), .sdr_d(sdr_d), .busy(busy), .done(done), .overflow(overflow),
    .write_count(write_count));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // SDRAM responder: acks each request after a per-request latency.
  bit  hold = 0;
  int  def_lat = 1, cur_lat = 1, wcnt = 0;
  int  lat_q[$];
  always @(posedge clk) begin
    #1;
    if (reset) wcnt = 0;
    else if (sdr_req !== sdr_ack && !hold) begin
      if (wcnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : def_lat;
      wcnt++;
      if (wcnt >= cur_lat) begin
        sdr_ack = sdr_req;
        wcnt = 0;
      end
    end
  end

  // Request monitor: records issued words, overlaps and instability.
  w_t   got_q[$];
  w_t   lat_w;
  logic prev_req = 0, prev_ack = 0;
  int   toggles = 0, overlap = 0, unstable = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (sdr_req !== prev_req) begin
        toggles++;
        if (prev_req !== prev_ack) overlap++;
        lat_w = '{sdr_a, sdr_ds, sdr_d};
        got_q.push_back(lat_w);
      end else if (sdr_req !== sdr_ack) begin
        if (w_t'({sdr_a, sdr_ds, sdr_d}) !== lat_w) unstable++;
      end
    end
    prev_req = sdr_req;
    prev_ack = sdr_ack;
  end

  // Reference model: packing rules applied to the byte stream.
  bit m_pv;
  w_t m_p;
  w_t exp_q[$];
  task automatic mdl_byte(input logic [23:0] a, input logic [7:0] d);
    logic [22:0] wa;
    wa = BASE + a[23:1];
    if (m_pv && m_p.a == wa) begin
      if (a[0]) m_p.d[15:8] = d; else m_p.d[7:0] = d;
      m_p.ds[a[0]] = 1'b1;
      if (m_p.ds == 2'b11) begin exp_q.push_back(m_p); m_pv = 0; end
    end else begin
      if (m_pv) exp_q.push_back(m_p);
      m_pv   = 1;
      m_p.a  = wa;
      m_p.ds = a[0] ? 2'b10 : 2'b01;
      m_p.d  = a[0] ? {d, 8'h00} : {8'h00, d};
    end
  endtask

  task automatic mdl_clear();
    m_pv = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dl_start();
    @(negedge clk);
    ioctl_download = 1;
    cycles(2);
  endtask

  task automatic send_byte(input logic [23:0] a, input logic [7:0] d, input bit obey);
    int t;
    t = 0;
    while (obey && ioctl_wait === 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, want 0", ioctl_wait, t);
    end
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 0;
  endtask

  task automatic dl_end(input int budget);
    int t;
    ioctl_download = 0;
    if (m_pv) begin exp_q.push_back(m_p); m_pv = 0; end
    t = 0;
    while (done !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, t);
    end
    cycles(2);
  endtask

  task automatic test_reset();
    reset = 1;
    cycles(3);
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if ({ioctl_wait, sdr_req, sdr_a, sdr_ds, sdr_d} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: wait=%b req=%b a=%h ds=%b d=%h, want all 0",
               ioctl_wait, sdr_req, sdr_a, sdr_ds, sdr_d);
    end
    n_cmp++;
    if ({busy, done, overflow, write_count} !== '0 || sdr_we !== 1'b1) begin
      n_err++;
      $display("FAIL reset_status: busy=%b done=%b ovf=%b cnt=%0d we=%b, want 0 0 0 0 1",
               busy, done, overflow, write_count, sdr_we);
    end
    cycles(2);
  endtask

  task automatic test_byte_pair();
    w_t want;
    mdl_clear();
    dl_start();
    send_byte(24'h000010, 8'h34, 1);
    send_byte(24'h000011, 8'h12, 1);
    dl_end(100);
    want = '{23'h100008, 2'b11, 16'h1234};
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      n_err++;
      $display("FAIL byte_pair: %0d reqs first=%h, want 1 req %h", got_q.size(),
               got_q.size() > 0 ? got_q[0] : w_t'('0), want);
    end
    n_cmp++;
    if (write_count !== 24'd1) begin
      n_err++;
      $display("FAIL byte_pair_count: write_count=%0d, want 1", write_count);
    end
  endtask

  task automatic test_lone_byte();
    w_t w0, w1;
    mdl_clear();
    dl_start();
    n_cmp++;
    if (done !== 1'b0 || write_count !== 24'd0) begin
      n_err++;
      $display("FAIL rise_clear: done=%b cnt=%0d after rising download, want 0 0", done, write_count);
    end
    send_byte(24'h000021, 8'hAB, 1);
    send_byte(24'h000040, 8'hCD, 1);
    dl_end(100);
    w0 = '{23'h100010, 2'b10, 16'hAB00};
    w1 = '{23'h100020, 2'b01, 16'h00CD};
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== w0 || got_q[1] !== w1) begin
      n_err++;
      $display("FAIL lone_byte: %0d reqs, want 2 reqs %h %h", got_q.size(), w0, w1);
    end
    n_cmp++;
    if (done !== 1'b1 || write_count !== 24'd2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL lone_byte_status: done=%b cnt=%0d busy=%b, want 1 2 0", done, write_count, busy);
    end
  endtask

  task automatic test_backpressure();
    mdl_clear();
    hold = 1;
    dl_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(24'(i), 8'(8'h50 + i), 0);
      if (i == 5) begin
        n_cmp++;
        if (ioctl_wait !== 1'b0) begin
          n_err++; $display("FAIL bp_wait_low: ioctl_wait=%b at occupancy 2, want 0", ioctl_wait);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (ioctl_wait !== 1'b1) begin
          n_err++; $display("FAIL bp_wait_high: ioctl_wait=%b at occupancy 3, want 1", ioctl_wait);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (overflow !== 1'b0) begin
          n_err++; $display("FAIL bp_no_ovf: overflow=%b on push into last slot, want 0", overflow);
        end
      end
      if (i == 11) begin
        n_cmp++;
        if (overflow !== 1'b1) begin
          n_err++; $display("FAIL bp_ovf: overflow=%b after push into full FIFO, want 1", overflow);
        end
      end
      @(negedge clk);
    end
    cycles(18);
    hold = 0;
    dl_end(200);
    for (int k = 0; k < 5; k++) exp_q.push_back('{BASE + 23'(k), 2'b11, {8'(8'h51 + 2*k), 8'(8'h50 + 2*k)}});
    n_cmp++;
    if (got_q.size() != 5 || got_q != exp_q) begin
      n_err++;
      $display("FAIL bp_words: %0d reqs issued, want 5 words 0..4", got_q.size());
    end
    n_cmp++;
    if (write_count !== 24'd5 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL bp_status: cnt=%0d ovf=%b, want 5 1", write_count, overflow);
    end
  endtask

  task automatic test_ack_latency();
    int t0;
    mdl_clear();
    t0 = toggles;
    lat_q = '{1, 7, 30};
    dl_start();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: overflow=%b after rising download, want 0", overflow);
    end
    for (int i = 0; i < 6; i++) begin
      send_byte(24'h000200 + 24'(i), 8'($urandom), 1);
      mdl_byte(24'h000200 + 24'(i), ioctl_dout);
    end
    dl_end(400);
    n_cmp++;
    if (toggles - t0 != 3 || overlap != 0 || unstable != 0) begin
      n_err++;
      $display("FAIL ack_latency: toggles=%0d overlap=%0d unstable=%0d, want 3 0 0",
               toggles - t0, overlap, unstable);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ack_latency_word%0d: got %h, want %h", i,
                 i < got_q.size() ? got_q[i] : w_t'('0), exp_q[i]);
      end
    end
    n_cmp++;
    if (write_count !== 24'd3) begin
      n_err++; $display("FAIL ack_latency_count: cnt=%0d, want 3", write_count);
    end
  endtask

  task automatic test_random();
    logic [23:0] cur;
    logic [7:0]  d;
    int n, c;
    for (int it = 0; it < 4; it++) begin
      mdl_clear();
      def_lat = $urandom_range(1, 4);
      cur = (it == 0) ? 24'hFFFFF0 : 24'($urandom);
      n = $urandom_range(20, 40);
      dl_start();
      for (int i = 0; i < n; i++) begin
        c = $urandom_range(0, 9);
        if (i > 0) begin
          if (c < 7)       cur = cur + 24'd1;
          else if (c == 7) cur = 24'($urandom);
          else if (c == 8) cur = cur ^ 24'd1;
        end
        d = 8'($urandom);
        send_byte(cur, d, 1);
        mdl_byte(cur, d);
        cycles($urandom_range(0, 3));
      end
      dl_end(500);
      n_cmp++;
      if (got_q.size() != exp_q.size() || write_count !== 24'(exp_q.size()) || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_count: reqs=%0d cnt=%0d ovf=%b, want %0d %0d 0", it,
                 got_q.size(), write_count, overflow, exp_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rand%0d_word%0d: got %h, want %h", it, i,
                   i < got_q.size() ? got_q[i] : w_t'('0), exp_q[i]);
        end
      end
    end
    def_lat = 1;
  endtask

  task automatic test_reset_mid();
    int t0;
    mdl_clear();
    dl_start();
    send_byte(24'h000300, 8'h11, 1);
    send_byte(24'h000301, 8'h22, 1);
    cycles(8);
    if (sdr_ack !== 1'b1) begin
      send_byte(24'h000302, 8'h33, 1);
      send_byte(24'h000303, 8'h44, 1);
      cycles(8);
    end
    hold = 1;
    send_byte(24'h000304, 8'h55, 1);
    send_byte(24'h000305, 8'h66, 1);
    cycles(4);
    n_cmp++;
    if (sdr_req !== 1'b0 || sdr_ack !== 1'b1 || write_count === 24'd0) begin
      n_err++;
      $display("FAIL rst_pre: req=%b ack=%b cnt=%0d, want 0 1 nonzero", sdr_req, sdr_ack, write_count);
    end
    reset = 1;
    ioctl_download = 0;
    cycles(2);
    reset = 0;
    hold = 0;
    t0 = toggles;
    @(negedge clk);
    n_cmp++;
    if (sdr_req !== 1'b1 || write_count !== 24'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: req=%b cnt=%0d busy=%b, want 1 0 0", sdr_req, write_count, busy);
    end
    cycles(10);
    n_cmp++;
    if (toggles != t0 || sdr_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_no_toggle: %0d new toggles req=%b, want 0 1", toggles - t0, sdr_req);
    end
  endtask

  initial begin
    test_reset();
    test_byte_pair();
    test_lone_byte();
    test_backpressure();
    test_ack_latency();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
